// File: rtl/add_accumulator.sv
// Multi-beat unsigned adder with sticky carry flag and a one-deep result hold.
// Optional saturation build: define ADD_ACCUMULATOR_SATURATE_EN.
module add_accumulator #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] operand,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic [7:0]       beat_count,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             overflow_next;
    logic [7:0]       count_next;
    logic [WIDTH:0]   sum;

    // Handshake flags come straight from state (plus reset), never from out_ready.
    assign in_ready  = rst || (state == ACCUM);
    assign out_valid = !rst && (state == HOLD);
    assign result    = acc;
    assign sum       = {1'b0, acc} + {1'b0, operand};

    // Next-state and datapath: add beats in ACCUM, wait for the consumer in HOLD.
    always_comb begin
        state_next    = state;
        acc_next      = acc;
        overflow_next = overflow;
        count_next    = beat_count;
        unique case (state)
            ACCUM: begin
                if (in_valid) begin
                    count_next = beat_count + 8'd1;
                    if (sum[WIDTH]) begin
                        overflow_next = 1'b1;
                    end
`ifdef ADD_ACCUMULATOR_SATURATE_EN
                    if (sum[WIDTH] || overflow) begin
                        acc_next = {WIDTH{1'b1}};
                    end else begin
                        acc_next = sum[WIDTH-1:0];
                    end
`else
                    acc_next = sum[WIDTH-1:0];
`endif
                    if (in_last) begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_next      = '0;
                    overflow_next = 1'b0;
                    count_next    = 8'd0;
                    state_next    = ACCUM;
                end
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

    // State register; reset discards any sum in progress or held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ACCUM;
            acc        <= '0;
            overflow   <= 1'b0;
            beat_count <= 8'd0;
        end else begin
            state      <= state_next;
            acc        <= acc_next;
            overflow   <= overflow_next;
            beat_count <= count_next;
        end
    end

endmodule

// File: tb/tb_add_accumulator.sv
// Directed self-checking bench for add_accumulator (WIDTH=12).
// Expected values are hand-computed per scenario.
module tb_add_accumulator;

    logic        clk;
    logic        rst;
    logic [11:0] operand;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [11:0] result;
    logic        overflow;
    logic [7:0]  beat_count;
    logic        out_valid;
    logic        out_ready;

    int cmp_count;
    int err_count;

    add_accumulator #(.WIDTH(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .operand   (operand),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .result    (result),
        .overflow  (overflow),
        .beat_count(beat_count),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and clock it in; in_valid stays as left for back-to-back use.
    task automatic beat(input logic [11:0] v, input logic last);
        operand  = v;
        in_valid = 1'b1;
        in_last  = last;
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        operand  = '0;
    endtask

    task automatic test_reset();
        idle();
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        cmp_count++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            err_count++;
            $display("FAIL reset_during in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        rst = 1'b0;
        tick();
        cmp_count++;
        if (result !== 12'd0 || overflow !== 1'b0 || beat_count !== 8'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            err_count++;
            $display("FAIL reset_state res=%0d ovf=%b cnt=%0d ov=%b ir=%b want 0/0/0/0/1",
                     result, overflow, beat_count, out_valid, in_ready);
        end
    endtask

    task automatic test_basic_sum();
        out_ready = 1'b1;
        beat(12'd100, 1'b0);
        beat(12'd200, 1'b0);
        cmp_count++;
        if (out_valid !== 1'b0 || result !== 12'd300 || beat_count !== 8'd2) begin
            err_count++;
            $display("FAIL basic_mid ov=%b res=%0d cnt=%0d want 0/300/2", out_valid, result, beat_count);
        end
        beat(12'd300, 1'b1);
        idle();
        cmp_count++;
        if (out_valid !== 1'b1 || result !== 12'd600 || overflow !== 1'b0 || beat_count !== 8'd3) begin
            err_count++;
            $display("FAIL basic_result ov=%b res=%0d ovf=%b cnt=%0d want 1/600/0/3",
                     out_valid, result, overflow, beat_count);
        end
        tick();
        cmp_count++;
        if (out_valid !== 1'b0 || result !== 12'd0 || beat_count !== 8'd0 || in_ready !== 1'b1) begin
            err_count++;
            $display("FAIL basic_clear ov=%b res=%0d cnt=%0d ir=%b want 0/0/0/1",
                     out_valid, result, beat_count, in_ready);
        end
    endtask

    task automatic test_overflow();
        logic [11:0] want;
`ifdef ADD_ACCUMULATOR_SATURATE_EN
        want = 12'd4095;
`else
        want = 12'd104;
`endif
        out_ready = 1'b0;
        beat(12'd4000, 1'b0);
        cmp_count++;
        if (overflow !== 1'b0 || result !== 12'd4000) begin
            err_count++;
            $display("FAIL ovf_first ovf=%b res=%0d want 0/4000", overflow, result);
        end
        beat(12'd200, 1'b1);
        idle();
        cmp_count++;
        if (out_valid !== 1'b1 || result !== want || overflow !== 1'b1 || beat_count !== 8'd2) begin
            err_count++;
            $display("FAIL ovf_result ov=%b res=%0d ovf=%b cnt=%0d want 1/%0d/1/2",
                     out_valid, result, overflow, beat_count, want);
        end
        out_ready = 1'b1;
        tick();
        cmp_count++;
        if (overflow !== 1'b0 || result !== 12'd0 || out_valid !== 1'b0) begin
            err_count++;
            $display("FAIL ovf_clear ovf=%b res=%0d ov=%b want 0/0/0", overflow, result, out_valid);
        end
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        beat(12'd1, 1'b0);
        beat(12'd2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_last  = 1'b1;
            operand  = (i % 2 == 0) ? 12'd55 : 12'd4095;
            #1;
            cmp_count++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 12'd3 ||
                beat_count !== 8'd2 || overflow !== 1'b0) begin
                err_count++;
                $display("FAIL hold_cycle%0d ir=%b ov=%b res=%0d cnt=%0d ovf=%b want 0/1/3/2/0",
                         i, in_ready, out_valid, result, beat_count, overflow);
            end
            tick();
        end
        idle();
        out_ready = 1'b1;
        tick();
        cmp_count++;
        if (out_valid !== 1'b0 || result !== 12'd0 || beat_count !== 8'd0) begin
            err_count++;
            $display("FAIL hold_release ov=%b res=%0d cnt=%0d want 0/0/0", out_valid, result, beat_count);
        end
    endtask

    task automatic test_reset_midsum();
        out_ready = 1'b0;
        beat(12'd10, 1'b0);
        beat(12'd20, 1'b0);
        operand  = 12'd50;
        in_valid = 1'b1;
        in_last  = 1'b1;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        cmp_count++;
        if (result !== 12'd0 || beat_count !== 8'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            err_count++;
            $display("FAIL rst_mid_state res=%0d cnt=%0d ov=%b ir=%b want 0/0/0/1",
                     result, beat_count, out_valid, in_ready);
        end
        beat(12'd5, 1'b1);
        idle();
        cmp_count++;
        if (out_valid !== 1'b1 || result !== 12'd5 || beat_count !== 8'd1) begin
            err_count++;
            $display("FAIL rst_mid_next ov=%b res=%0d cnt=%0d want 1/5/1", out_valid, result, beat_count);
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_wrap_256();
        out_ready = 1'b0;
        for (int i = 0; i < 255; i++) begin
            beat(12'd0, 1'b0);
        end
        cmp_count++;
        if (beat_count !== 8'd255 || out_valid !== 1'b0) begin
            err_count++;
            $display("FAIL wrap_255 cnt=%0d ov=%b want 255/0", beat_count, out_valid);
        end
        beat(12'd0, 1'b1);
        idle();
        cmp_count++;
        if (out_valid !== 1'b1 || result !== 12'd0 || beat_count !== 8'd0 || overflow !== 1'b0) begin
            err_count++;
            $display("FAIL wrap_256 ov=%b res=%0d cnt=%0d ovf=%b want 1/0/0/0",
                     out_valid, result, beat_count, overflow);
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        beat(12'd9, 1'b1);
        operand   = 12'd7;
        in_valid  = 1'b1;
        in_last   = 1'b1;
        out_ready = 1'b1;
        #1;
        cmp_count++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 12'd9) begin
            err_count++;
            $display("FAIL b2b_hold ir=%b ov=%b res=%0d want 0/1/9", in_ready, out_valid, result);
        end
        tick();
        cmp_count++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || beat_count !== 8'd0 || result !== 12'd0) begin
            err_count++;
            $display("FAIL b2b_handshake ir=%b ov=%b cnt=%0d res=%0d want 1/0/0/0",
                     in_ready, out_valid, beat_count, result);
        end
        tick();
        idle();
        cmp_count++;
        if (out_valid !== 1'b1 || result !== 12'd7 || beat_count !== 8'd1) begin
            err_count++;
            $display("FAIL b2b_single ov=%b res=%0d cnt=%0d want 1/7/1", out_valid, result, beat_count);
        end
        tick();
        out_ready = 1'b0;
        beat(12'd1, 1'b0);
        beat(12'd2, 1'b0);
        beat(12'd3, 1'b0);
        beat(12'd4, 1'b1);
        idle();
        cmp_count++;
        if (out_valid !== 1'b1 || result !== 12'd10 || beat_count !== 8'd4) begin
            err_count++;
            $display("FAIL b2b_stream ov=%b res=%0d cnt=%0d want 1/10/4", out_valid, result, beat_count);
        end
        out_ready = 1'b1;
        tick();
    endtask

    initial begin
        cmp_count = 0;
        err_count = 0;
        rst       = 1'b1;
        out_ready = 1'b0;
        idle();
        test_reset();
        test_basic_sum();
        test_overflow();
        test_hold();
        test_reset_midsum();
        test_wrap_256();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule

// File: doc/add_accumulator.md
ADD_ACCUMULATOR -- requirements
Module: add_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 12, meaning operand, accumulator and result width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port operand  input  WIDTH  unsigned addend for the current beat.
REQ-005 SHALL have port in_valid  input  1  operand beat presented.
REQ-006 SHALL have port in_last  input  1  marks the final beat of a sum; sampled only on an accepted beat.
REQ-007 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-008 SHALL have port result  output  WIDTH  accumulated sum, stable while out_valid=1.
REQ-009 SHALL have port overflow  output  1  sticky: some add in this sum carried out of WIDTH bits.
REQ-010 SHALL have port beat_count  output  8  number of beats in this sum, wraps 255->0.
REQ-011 SHALL have port out_valid  output  1  result/overflow/beat_count valid.
REQ-012 SHALL have port out_ready  input  1  consumer takes the result.

Function
REQ-013 SHALL have exactly two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-014 SHALL accept a beat when in_valid=1 and in_ready=1.
REQ-015 SHALL, on each accepted beat, form a WIDTH+1-bit sum acc+operand; carry bit set -> overflow set to 1 (never cleared within a sum).
REQ-016 SHALL, on each accepted beat, store the low WIDTH bits of the sum in acc (modulo 2^WIDTH) unless REQ-029 applies.
REQ-017 SHALL increment beat_count by 1 per accepted beat, wrapping 255->0 with no flag.
REQ-018 SHALL transition ACCUM->HOLD on the clock edge that accepts a beat with in_last=1; that beat is included in the sum.
REQ-019 SHALL assert out_valid in the cycle after the last beat is accepted (latency 1 cycle).
REQ-020 SHALL drive result=acc continuously; out_valid qualifies it.
REQ-021 SHALL hold result, overflow, beat_count and out_valid unchanged in HOLD until out_valid=1 and out_ready=1.
REQ-022 SHALL, on the edge where out_valid=1 and out_ready=1, clear acc, overflow and beat_count to 0 and return to ACCUM.
REQ-023 SHALL ignore in_valid, operand and in_last while in HOLD; in_ready=0 there, no combinational path from out_ready to in_ready.
REQ-024 SHALL treat a single beat with in_last=1 from a cleared state as a one-operand sum (result=operand, beat_count=1).
REQ-025 SHALL accept back-to-back beats every cycle in ACCUM with no bubble.

Reset
REQ-026 SHALL, when rst=1 at a clock edge, enter ACCUM with acc=0, overflow=0, beat_count=0, out_valid=0, in_ready=1 on the following cycle.
REQ-027 SHALL give rst priority over any simultaneous accepted beat or output handshake; a sum in progress or held result is discarded.
REQ-028 SHALL drive in_ready=1 and out_valid=0 during and after reset, regardless of other inputs.

Configuration
REQ-029 SHALL, with macro ADD_ACCUMULATOR_SATURATE_EN defined, load acc with all-ones (4095 for WIDTH=12) on any carry and keep it there for the rest of the sum; overflow still set.
REQ-030 SHALL, with ADD_ACCUMULATOR_SATURATE_EN undefined, wrap acc modulo 2^WIDTH on carry; overflow still set.

Verification
REQ-031 SHALL cover: beats 100, 200, 300(last) with out_ready=1 -> out_valid one cycle after last, result=600, overflow=0, beat_count=3, then cleared.
REQ-032 SHALL cover: beats 4000, 200(last), macro undefined -> result=104, overflow=1; macro defined -> result=4095, overflow=1.
REQ-033 SHALL cover: sum held with out_ready=0 for 5 cycles while in_valid=1 toggles operand -> result/beat_count/overflow unchanged, in_ready=0 throughout.
REQ-034 SHALL cover: rst=1 after two beats (10, 20) in ACCUM -> next sum 5(last) gives result=5, beat_count=1.
REQ-035 SHALL cover: 256 beats of 0 with in_last on the 256th -> result=0, beat_count=0, overflow=0.
REQ-036 SHALL cover: single beat 7 with in_last=1 accepted on same edge that previous result handshakes -> not possible (in_ready=0 in HOLD); beat accepted next cycle, result=7, beat_count=1.
